// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer.
//   - state_t : sequencer FSM encoding (IDLE/SETUP/START/WAIT/GAP)
//   - req_t   : one 12-bit queued request {cs, mode, data}
//   - CS_NONE : slave-select value meaning "no slave"
//   - MODE_*  : SPI mode (CPOL,CPHA) codes
//   - BYTE_W  : width of one SPI byte
package spi_pkg;

    localparam int BYTE_W  = 8;
    localparam int ENTRY_W = 12;

    localparam logic [1:0] CS_NONE = 2'b00;

    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0]        cs;
        logic [1:0]        mode;
        logic [BYTE_W-1:0] data;
    } req_t;

endpackage

// File: rtl/spi_req_fifo.sv
// Request FIFO for the SPI transaction sequencer.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_data write one entry (ignored when full unless popping the same cycle)
//   pop, pop_data   pop_data is the head entry; pop advances it (ignored when empty)
//   full, empty     occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate counter.
module spi_req_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    req_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push while full is only accepted when a pop frees the head slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Upstream command stage for the SPI master. Buffers transfer requests in a FIFO
// and issues them one at a time: chip-select setup, start pulse, wait for done
// (or timeout), chip-select gap, response.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   req_valid/req_ready, req_cs/mode/data   request port (req_cs==0 is dropped and counted)
//   rsp_valid/rsp_ready, rsp_data/cs/timeout response port, one per issued request
//   m_cs, m_mode, m_tx_data, m_start    drive to the SPI master
//   m_done, m_rx_data                   completion from the SPI master
//   drop_cnt                            saturating count of dropped requests
//   busy                                registered: FSM not idle or FIFO not empty
//   fsm_state                           current FSM state, for observation
// Handshake rule (both ports): a transfer happens on a rising edge where valid
// and ready are both 1. A valid source holds valid and its payload stable until
// that edge; ready may change freely and does not depend on valid.
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SETUP_CYC   = 2,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cs,
    input  logic [1:0]        req_mode,
    input  logic [BYTE_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BYTE_W-1:0] rsp_data,
    output logic [1:0]        rsp_cs,
    output logic              rsp_timeout,
    output logic [1:0]        m_cs,
    output logic [1:0]        m_mode,
    output logic [BYTE_W-1:0] m_tx_data,
    output logic              m_start,
    input  logic              m_done,
    input  logic [BYTE_W-1:0] m_rx_data,
    output logic [7:0]        drop_cnt,
    output logic              busy,
    output state_t            fsm_state
);

    localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYC - 1);
    // The timeout counter is 0 in the first WAIT cycle (one cycle after m_start),
    // so the abort decision is taken when it reads TIMEOUT_CYC-2; the response
    // then appears exactly TIMEOUT_CYC cycles after m_start.
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 2);

    state_t            state;
    state_t            next_state;

    logic              ready_en;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    req_t              fifo_head;
    req_t              fifo_in;

    logic [7:0]        phase_cnt;
    logic [15:0]       tmo_cnt;
    logic [1:0]        cs_q;
    logic [1:0]        mode_q;
    logic [BYTE_W-1:0] tx_q;
    logic              rsp_valid_q;
    logic [BYTE_W-1:0] rsp_data_q;
    logic [1:0]        rsp_cs_q;
    logic              rsp_timeout_q;
    logic [7:0]        drop_q;
    logic              busy_q;

    // ready_en holds req_ready low while in reset and rises on the first clock after it.
    assign req_ready = ready_en && !fifo_full;
    assign fifo_push = req_valid && req_ready && (req_cs != CS_NONE);
    assign fifo_in   = '{cs: req_cs, mode: req_mode, data: req_data};

    spi_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // FSM: next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (!fifo_empty && !rsp_valid_q) next_state = ST_SETUP;
            ST_SETUP: if (phase_cnt == SETUP_LAST)     next_state = ST_START;
            ST_START: next_state = ST_WAIT;
            // m_done is tested first so a done in the timeout cycle still wins.
            ST_WAIT:  if (m_done || tmo_cnt == TMO_LAST) next_state = ST_GAP;
            // Leave only once the minimum gap is served and the response is gone
            // or is being accepted this cycle.
            ST_GAP:   if (phase_cnt == GAP_LAST && (!rsp_valid_q || rsp_ready)) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        fifo_pop  = (state == ST_IDLE) && (next_state == ST_SETUP);
        m_start   = (state == ST_START);
        m_cs      = CS_NONE;
        if (state == ST_SETUP || state == ST_START || state == ST_WAIT) m_cs = cs_q;
        fsm_state = state;
    end

    // Transfer registers, counters, response register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en      <= 1'b0;
            phase_cnt     <= '0;
            tmo_cnt       <= '0;
            cs_q          <= CS_NONE;
            mode_q        <= '0;
            tx_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_cs_q      <= CS_NONE;
            rsp_timeout_q <= 1'b0;
            drop_q        <= '0;
            busy_q        <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (fifo_pop) begin
                cs_q   <= fifo_head.cs;
                mode_q <= fifo_head.mode;
                tx_q   <= fifo_head.data;
            end

            // Shared by SETUP and GAP; restarts on every state change and
            // saturates at the end of the gap while waiting for the consumer.
            if (state != next_state)
                phase_cnt <= '0;
            else if (state == ST_SETUP || (state == ST_GAP && phase_cnt != GAP_LAST))
                phase_cnt <= phase_cnt + 8'd1;

            if (state == ST_START)     tmo_cnt <= '0;
            else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 16'd1;

            if (state == ST_WAIT && next_state == ST_GAP) begin
                rsp_valid_q   <= 1'b1;
                rsp_cs_q      <= cs_q;
                rsp_data_q    <= m_done ? m_rx_data : '0;
                rsp_timeout_q <= !m_done;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end

            if (req_valid && req_ready && req_cs == CS_NONE && drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;

            busy_q <= (state != ST_IDLE) || !fifo_empty;
        end
    end

    assign m_mode      = mode_q;
    assign m_tx_data   = tx_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_cs      = rsp_cs_q;
    assign rsp_timeout = rsp_timeout_q;
    assign drop_cnt    = drop_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
module tb_spi_txn_sequencer;
  import spi_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int SETUP_CYC   = 2;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_cs = 2'b00;
  logic [1:0] req_mode = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [1:0] rsp_cs;
  logic       rsp_timeout;
  logic [1:0] m_cs;
  logic [1:0] m_mode;
  logic [7:0] m_tx_data;
  logic       m_start;
  logic       m_done = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  logic [7:0] drop_cnt;
  logic       busy;
  state_t     fsm_state;

  spi_txn_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SETUP_CYC  (SETUP_CYC),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cs     (req_cs),
    .req_mode   (req_mode),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cs     (rsp_cs),
    .rsp_timeout(rsp_timeout),
    .m_cs       (m_cs),
    .m_mode     (m_mode),
    .m_tx_data  (m_tx_data),
    .m_start    (m_start),
    .m_done     (m_done),
    .m_rx_data  (m_rx_data),
    .drop_cnt   (drop_cnt),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / behavioural model ----------------
  // Transfers are tracked as event times: pop cycle, start cycle, response
  // cycle, accept cycle. Every output is derived from those each cycle.
  logic [11:0] exp_q[$];
  logic [11:0] cur;
  int  cyc = 0;
  bit  in_xfer = 0;
  int  pop_c, start_c, rsp_c, acc_c;
  logic [7:0] e_data;
  logic       e_to;
  bit  ready_ok = 0;
  int  drop_m = 0;
  bit  busy_src = 0;

  always @(negedge clk) begin
    bit   xfer_act, exp_rv, exp_ready, exp_start, was_x, nxt_busy;
    cyc++;
    if (reset) begin
      exp_q.delete();
      in_xfer  = 0;
      ready_ok = 0;
      drop_m   = 0;
      busy_src = 0;
      check("rst_m_cs", 32'(m_cs), 0);
      check("rst_m_start", 32'(m_start), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_fields", {rsp_data, rsp_cs, rsp_timeout}, 0);
      check("rst_m_bus", {m_mode, m_tx_data}, 0);
      check("rst_drop_cnt", 32'(drop_cnt), 0);
      check("rst_busy", 32'(busy), 0);
    end else begin
      xfer_act  = in_xfer && cyc > pop_c && (rsp_c < 0 || cyc < rsp_c);
      exp_rv    = in_xfer && rsp_c >= 0 && cyc >= rsp_c && (acc_c < 0 || cyc <= acc_c);
      exp_start = in_xfer && cyc == start_c;
      exp_ready = ready_ok && (exp_q.size() < FIFO_DEPTH);

      check("m_cs", 32'(m_cs), xfer_act ? 32'(cur[11:10]) : 0);
      check("m_start", 32'(m_start), 32'(exp_start));
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("drop_cnt", 32'(drop_cnt), 32'(drop_m));
      check("busy", 32'(busy), 32'(busy_src));
      if (xfer_act) check("m_mode_data", {m_mode, m_tx_data}, 32'(cur[9:0]));
      if (exp_rv)   check("rsp_fields", {rsp_data, rsp_cs, rsp_timeout}, {e_data, cur[11:10], e_to});

      nxt_busy = (in_xfer && cyc > pop_c) || (exp_q.size() > 0);
      was_x = in_xfer;
      if (was_x) begin
        if (rsp_c < 0 && cyc > start_c) begin
          if (m_done) begin
            rsp_c = cyc + 1; e_data = m_rx_data; e_to = 1'b0;
          end else if (cyc == start_c + TIMEOUT_CYC - 1) begin
            rsp_c = cyc + 1; e_data = 8'h00; e_to = 1'b1;
          end
        end
        if (exp_rv && rsp_ready && acc_c < 0) acc_c = cyc;
        if (acc_c >= 0 && cyc + 1 >= rsp_c + GAP_CYC && cyc + 1 >= acc_c + 1) in_xfer = 0;
      end else if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        in_xfer = 1; pop_c = cyc; start_c = cyc + SETUP_CYC + 1; rsp_c = -1; acc_c = -1;
      end
      if (req_valid && exp_ready) begin
        if (req_cs != 2'b00) exp_q.push_back({req_cs, req_mode, req_data});
        else if (drop_m != 255) drop_m++;
      end
      busy_src = nxt_busy;
      ready_ok = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [1:0] cs, input logic [1:0] mode, input logic [7:0] data);
    int w = 0;
    req_valid = 1'b1; req_cs = cs; req_mode = mode; req_data = data;
    @(negedge clk);
    while (!req_ready && w < 400) begin w++; @(negedge clk); end
    check("req_accept", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_cs = 2'b00;
  endtask

  task automatic answer(input int d, input logic [7:0] rx);
    int w = 0;
    @(negedge clk);
    while (!m_start && w < 400) begin w++; @(negedge clk); end
    check("start_seen", 32'(m_start), 1);
    repeat (d) @(posedge clk);
    #1 m_done = 1'b1; m_rx_data = rx;
    @(posedge clk); #1 m_done = 1'b0; m_rx_data = 8'h00;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    @(negedge clk); n++;
    while (!m_start && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk); n++;
    while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (!(fsm_state == ST_IDLE && !busy && !rsp_valid) && w < 3000) begin w++; @(negedge clk); end
    check("drain", 32'(fsm_state == ST_IDLE && !busy && !rsp_valid), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n, gap_n, starts, seen_rv;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 1);
    check("post_reset_mcs", 32'(m_cs), 0);
    @(posedge clk); #1;

    // 1: single transfer, latency and gap
    send_req(2'b01, MODE_0, 8'hA5);
    fork
      answer(3, 8'h3C);
      begin
        wait_start(n);
        check("t1_start_latency", 32'(n), 4);
        wait_rsp(n);
        check("t1_rsp_latency", 32'(n), 4);
        check("t1_rsp", {rsp_data, rsp_cs, rsp_timeout}, {8'h3C, 2'b01, 1'b0});
        gap_n = 0;
        while (fsm_state == ST_GAP && gap_n < 50) begin
          if (m_cs == 2'b00) gap_n++;
          @(negedge clk);
        end
        check("t1_gap_len", 32'(gap_n), 4);
      end
    join
    wait_idle();
    @(posedge clk); #1;

    // 2: one transfer in flight, then 5 back-to-back requests (all time out)
    send_req(2'b01, MODE_0, 8'h10);
    send_req(2'b10, MODE_1, 8'h21);
    send_req(2'b11, MODE_2, 8'h32);
    send_req(2'b01, MODE_3, 8'h43);
    send_req(2'b10, MODE_0, 8'h54);
    @(negedge clk);
    check("t2_full_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    send_req(2'b11, MODE_1, 8'h65);
    wait_idle();
    @(posedge clk); #1;

    // 3: timeout exactly 64 cycles after m_start, then a normal transfer
    send_req(2'b10, MODE_3, 8'hC3);
    wait_start(n);
    wait_rsp(n);
    check("t3_timeout_latency", 32'(n), 64);
    check("t3_rsp", {rsp_data, rsp_cs, rsp_timeout}, {8'h00, 2'b10, 1'b1});
    @(posedge clk); #1;
    fork
      answer(7, 8'h5A);
      send_req(2'b11, MODE_1, 8'h96);
    join
    wait_rsp(n);
    check("t3_next_rsp", {rsp_data, rsp_cs, rsp_timeout}, {8'h5A, 2'b11, 1'b0});
    wait_idle();
    @(posedge clk); #1;

    // 4: response back-pressure holds the FSM in GAP
    rsp_ready = 1'b0;
    send_req(2'b01, MODE_1, 8'h55);
    send_req(2'b10, MODE_2, 8'h66);
    answer(2, 8'h11);
    wait_rsp(n);
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_start) starts++;
    end
    check("t4_no_start", 32'(starts), 0);
    check("t4_in_gap", 32'(fsm_state == ST_GAP), 1);
    check("t4_rsp_held", {rsp_valid, rsp_data, rsp_cs}, {1'b1, 8'h11, 2'b01});
    @(posedge clk); #1 rsp_ready = 1'b1;
    answer(5, 8'h22);
    wait_idle();
    @(posedge clk); #1;

    // 5: illegal cs=00 requests saturate drop_cnt
    req_valid = 1'b1; req_cs = 2'b00; req_mode = MODE_2; req_data = 8'hEE;
    repeat (300) @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("t5_drop_sat", 32'(drop_cnt), 32'hFF);
    check("t5_not_busy", 32'(busy), 0);
    @(posedge clk); #1;

    // 6: asynchronous reset during WAIT with two requests queued
    send_req(2'b01, MODE_1, 8'h81);
    send_req(2'b10, MODE_2, 8'h82);
    send_req(2'b11, MODE_3, 8'h83);
    wait_start(n);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6_async_mcs", 32'(m_cs), 0);
    check("t6_async_start", 32'(m_start), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 m_done = 1'b1; m_rx_data = 8'h77;
    @(posedge clk); #1 m_done = 1'b0; m_rx_data = 8'h00;
    starts = 0; seen_rv = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_start) starts++;
      if (rsp_valid) seen_rv++;
    end
    check("t6_no_start", 32'(starts), 0);
    check("t6_no_rsp", 32'(seen_rv), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_ready", 32'(req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
